// File: rtl/fios_result_collector_if.sv
// Result collector handshake bundle.
// FIOS_COLLECT_CARRY_EN widens result_o by one limb.
interface fios_result_collector_if #(
  parameter int WORD_WIDTH = 17,
  parameter int WORD_COUNT = 16
);
`ifdef FIOS_COLLECT_CARRY_EN
  localparam int NL = WORD_COUNT + 1;
`else
  localparam int NL = WORD_COUNT;
`endif
  localparam int RW = NL * WORD_WIDTH;

  logic                    start_i;
  logic                    P_valid_i;
  logic [2*WORD_WIDTH-1:0] P_i;
  logic [RW-1:0]           result_o;
  logic                    result_valid_o;
  logic                    result_ready_i;
  logic                    busy_o;
  logic                    overrun_o;

  modport master (
    output start_i,
    output P_valid_i,
    output P_i,
    output result_ready_i,
    input  result_o,
    input  result_valid_o,
    input  busy_o,
    input  overrun_o
  );

  modport slave (
    input  start_i,
    input  P_valid_i,
    input  P_i,
    input  result_ready_i,
    output result_o,
    output result_valid_o,
    output busy_o,
    output overrun_o
  );
endinterface

// File: rtl/fios_result_collector.sv
// Collects FIOS DSP result limbs into one word.
// FIOS_COLLECT_CARRY_EN adds the final carry limb.
module fios_result_collector #(
  parameter int WORD_WIDTH = 17,
  parameter int WORD_COUNT = 16
) (
  input logic                     clock_i,
  input logic                     reset_n_i,
  fios_result_collector_if.slave  bus
);
`ifdef FIOS_COLLECT_CARRY_EN
  localparam int NL = WORD_COUNT + 1;
`else
  localparam int NL = WORD_COUNT;
`endif
  localparam int RW = NL * WORD_WIDTH;
  localparam int CW =
    (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(WORD_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [RW-1:0] result_q, result_d;
  logic          ovr_q, ovr_d;

  logic          restart;
  logic          wr;
  logic [CW-1:0] idx;

`ifndef FIOS_COLLECT_CARRY_EN
  logic unused_hi;
  assign unused_hi =
    ^bus.P_i[2*WORD_WIDTH-1:WORD_WIDTH];
`endif

  // State, limb count, result and sticky overrun registers
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      result_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      result_q <= result_d;
      ovr_q    <= ovr_d;
    end
  end

  // Next state: restart, limb capture, hold/release
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    result_d = result_q;
    ovr_d    = ovr_q;
    restart  = 1'b0;
    wr       = 1'b0;
    idx      = count_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          restart = 1'b1;
        end else if (bus.P_valid_i) begin
          ovr_d = 1'b1;
        end
      end
      COLLECT: begin
        if (bus.start_i) begin
          restart = 1'b1;
        end else if (bus.P_valid_i) begin
          wr = 1'b1;
        end
      end
      HOLD: begin
        if (bus.start_i || bus.P_valid_i) begin
          ovr_d = 1'b1;
        end
        if (bus.result_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A start discards any partial frame; a
    // coincident strobe becomes limb 0.
    if (restart) begin
      state_d  = COLLECT;
      count_d  = '0;
      result_d = '0;
      ovr_d    = 1'b0;
      idx      = '0;
      wr       = bus.P_valid_i;
    end

    if (wr) begin
      for (int i = 0; i < WORD_COUNT; i++) begin
        if (idx == CW'(i)) begin
          result_d[i*WORD_WIDTH +: WORD_WIDTH] =
            bus.P_i[WORD_WIDTH-1:0];
        end
      end
      if (idx == LAST) begin
        state_d = HOLD;
        count_d = '0;
`ifdef FIOS_COLLECT_CARRY_EN
        result_d[WORD_COUNT*WORD_WIDTH +: WORD_WIDTH] =
          bus.P_i[2*WORD_WIDTH-1:WORD_WIDTH];
`endif
      end else begin
        count_d = idx + CW'(1);
      end
    end
  end

  assign bus.result_o       = result_q;
  assign bus.result_valid_o = (state_q == HOLD);
  assign bus.busy_o         = (state_q != IDLE);
  assign bus.overrun_o      = ovr_q;

endmodule
